// File: rtl/rgb_led_sequencer.sv
// rgb_led_sequencer: walks a programmable table of colour steps, fading each
// channel one level per tick toward the step target and then holding it.
module rgb_led_sequencer #(
  parameter int COUNT = 7,
  parameter int STEPS = 4,
  parameter int TICK_DIV = 1000,
  parameter int HOLD_W = 8,
  localparam int CW = $clog2(COUNT + 1),
  localparam int SW = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [SW-1:0]     wr_addr,
  input  logic [CW-1:0]     wr_r,
  input  logic [CW-1:0]     wr_g,
  input  logic [CW-1:0]     wr_b,
  input  logic [HOLD_W-1:0] wr_hold,
  input  logic [SW-1:0]     cfg_last,
  input  logic              cfg_loop,
  input  logic              start,
  input  logic              stop,
  output logic              ctrl_on,
  output logic [CW-1:0]     ctrl_r,
  output logic [CW-1:0]     ctrl_g,
  output logic [CW-1:0]     ctrl_b,
  output logic              busy,
  output logic [SW-1:0]     step,
  output logic              done
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, FADE, HOLD} state_t;
  state_t state;
  logic [PW-1:0] presc;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CW-1:0] tab_r [STEPS];
  logic [CW-1:0] tab_g [STEPS];
  logic [CW-1:0] tab_b [STEPS];
  logic [HOLD_W-1:0] tab_h [STEPS];
  logic tick, go, at_target;
  logic [SW-1:0] last;
  logic [CW-1:0] tgt_r, tgt_g, tgt_b;
  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return v > CW'(COUNT) ? CW'(COUNT) : v;
  endfunction
  function automatic logic [CW-1:0] toward(input logic [CW-1:0] c, input logic [CW-1:0] t);
    return c < t ? c + CW'(1) : c > t ? c - CW'(1) : c;
  endfunction
  always_comb begin
    tick = presc == PW'(TICK_DIV - 1);
    go = state == IDLE && start && !stop;
    last = int'(cfg_last) >= STEPS ? SW'(STEPS - 1) : cfg_last;
    tgt_r = tab_r[step];
    tgt_g = tab_g[step];
    tgt_b = tab_b[step];
    at_target = ctrl_r == tgt_r && ctrl_g == tgt_g && ctrl_b == tgt_b;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      presc <= '0;
      hold_cnt <= '0;
      step <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      ctrl_on <= 1'b0;
      ctrl_r <= '0;
      ctrl_g <= '0;
      ctrl_b <= '0;
      for (int i = 0; i < STEPS; i++) begin
        tab_r[i] <= '0;
        tab_g[i] <= '0;
        tab_b[i] <= '0;
        tab_h[i] <= '0;
      end
    end else begin
      presc <= go || tick ? '0 : presc + PW'(1);
      done <= 1'b0;
      if (wr_en && int'(wr_addr) < STEPS) begin
        tab_r[wr_addr] <= sat(wr_r);
        tab_g[wr_addr] <= sat(wr_g);
        tab_b[wr_addr] <= sat(wr_b);
        tab_h[wr_addr] <= wr_hold;
      end
      if (stop) begin
        state <= IDLE;
        busy <= 1'b0;
        ctrl_on <= 1'b0;
      end else if (go) begin
        state <= FADE;
        step <= '0;
        busy <= 1'b1;
        ctrl_on <= 1'b1;
      end else if (tick && state == FADE) begin
        if (at_target) begin
          hold_cnt <= tab_h[step];
          state <= HOLD;
        end else begin
          ctrl_r <= toward(ctrl_r, tgt_r);
          ctrl_g <= toward(ctrl_g, tgt_g);
          ctrl_b <= toward(ctrl_b, tgt_b);
        end
      end else if (tick && state == HOLD) begin
        if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);
        else if (step != last) begin
          step <= step + SW'(1);
          state <= FADE;
        end else if (cfg_loop) begin
          step <= '0;
          state <= FADE;
        end else begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rgb_led_sequencer.sv
// tb_rgb_led_sequencer: directed steps; every output change is matched, with its
// cycle, against an expected-event queue filled before each sequence starts.
module tb_rgb_led_sequencer;
  logic clk = 0;
  logic reset_n = 0;
  logic wr_en = 0;
  logic [1:0] wr_addr = 0;
  logic [2:0] wr_r = 0, wr_g = 0, wr_b = 0;
  logic [7:0] wr_hold = 0;
  logic [1:0] cfg_last = 0;
  logic cfg_loop = 0;
  logic start_a = 0, stop_a = 0, start_b = 0, stop_b = 0;
  logic on_a, busy_a, done_a, on_b, busy_b, done_b;
  logic [2:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic [1:0] step_a, step_b;
  logic sel = 0, psel = 0;
  logic [13:0] obs_a, obs_b, obs, pv = 0;
  int cyc = 0, checks = 0, errs = 0, s;
  typedef struct {logic [13:0] v; int c;} ev_t;
  ev_t q[$];

  rgb_led_sequencer #(.COUNT(7), .STEPS(4), .TICK_DIV(4), .HOLD_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_r(wr_r), .wr_g(wr_g),
    .wr_b(wr_b), .wr_hold(wr_hold), .cfg_last(cfg_last), .cfg_loop(cfg_loop), .start(start_a),
    .stop(stop_a), .ctrl_on(on_a), .ctrl_r(r_a), .ctrl_g(g_a), .ctrl_b(b_a), .busy(busy_a),
    .step(step_a), .done(done_a));
  rgb_led_sequencer #(.COUNT(5), .STEPS(3), .TICK_DIV(1), .HOLD_W(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_r(wr_r), .wr_g(wr_g),
    .wr_b(wr_b), .wr_hold(wr_hold), .cfg_last(cfg_last), .cfg_loop(cfg_loop), .start(start_b),
    .stop(stop_b), .ctrl_on(on_b), .ctrl_r(r_b), .ctrl_g(g_b), .ctrl_b(b_b), .busy(busy_b),
    .step(step_b), .done(done_b));

  assign obs_a = {on_a, busy_a, done_a, step_a, r_a, g_a, b_a};
  assign obs_b = {on_b, busy_b, done_b, step_b, r_b, g_b, b_b};
  assign obs = sel ? obs_b : obs_a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [13:0] pk(int on, int bsy, int dn, int st, int r, int g, int b);
    return {1'(on), 1'(bsy), 1'(dn), 2'(st), 3'(r), 3'(g), 3'(b)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic ex(int c, int on, int bsy, int dn, int st, int r, int g, int b);
    q.push_back('{v: pk(on, bsy, dn, st, r, g, b), c: c});
  endtask

  task automatic wr(int a, int r, int g, int b, int h);
    wr_en = 1; wr_addr = 2'(a); wr_r = 3'(r); wr_g = 3'(g); wr_b = 3'(b); wr_hold = 8'(h);
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic go(input bit on_b_dut);
    if (on_b_dut) start_b = 1; else start_a = 1;
    @(negedge clk);
    start_a = 0; start_b = 0;
  endtask

  // Monitor: each change of the observed outputs must match the queue head, cycle included.
  initial forever begin
    ev_t e;
    @(negedge clk);
    if (!reset_n || sel !== psel) begin
      pv = obs;
      psel = sel;
    end else if (obs !== pv) begin
      e = '{v: '0, c: -1};
      if (q.size() > 0) e = q.pop_front();
      chk("event", 64'({obs, cyc}), 64'({e.v, e.c}));
      pv = obs;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_a", 64'(obs_a), 64'(0));
    chk("reset_b", 64'(obs_b), 64'(0));
    reset_n = 1;
    @(negedge clk);
    // single step with saturating ramp on r and early stop on b
    wr(0, 7, 0, 3, 2);
    cfg_last = 0; cfg_loop = 0;
    s = cyc + 1;
    ex(s, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 7; k++) ex(s + 4 * k, 1, 1, 0, 0, k, 0, k < 3 ? k : 3);
    ex(s + 44, 1, 0, 1, 0, 7, 0, 3);
    ex(s + 45, 1, 0, 0, 0, 7, 0, 3);
    go(0);
    repeat (50) @(negedge clk);
    chk("single_q", 64'(q.size()), 64'(0));
    chk("single_end", 64'(obs_a), 64'(pk(1, 0, 0, 0, 7, 0, 3)));
    // restart at target, stop during HOLD
    s = cyc + 1;
    ex(s, 1, 1, 0, 0, 7, 0, 3);
    ex(s + 10, 0, 0, 0, 0, 7, 0, 3);
    go(0);
    repeat (9) @(negedge clk);
    stop_a = 1;
    @(negedge clk);
    stop_a = 0;
    repeat (5) @(negedge clk);
    chk("stop_q", 64'(q.size()), 64'(0));
    start_a = 1; stop_a = 1;
    @(negedge clk);
    start_a = 0; stop_a = 0;
    repeat (10) @(negedge clk);
    chk("collide", 64'(obs_a), 64'(pk(0, 0, 0, 0, 7, 0, 3)));
    // looping two-step sequence
    wr(0, 7, 7, 7, 0);
    wr(1, 0, 0, 0, 0);
    cfg_last = 1; cfg_loop = 1;
    s = cyc + 1;
    ex(s, 1, 1, 0, 0, 7, 0, 3);
    for (int k = 1; k <= 7; k++) ex(s + 4 * k, 1, 1, 0, 0, 7, k, k < 4 ? 3 + k : 7);
    ex(s + 36, 1, 1, 0, 1, 7, 7, 7);
    for (int k = 1; k <= 7; k++) ex(s + 36 + 4 * k, 1, 1, 0, 1, 7 - k, 7 - k, 7 - k);
    ex(s + 72, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 7; k++) ex(s + 72 + 4 * k, 1, 1, 0, 0, k, k, k);
    ex(s + 108, 1, 1, 0, 1, 7, 7, 7);
    for (int k = 1; k <= 3; k++) ex(s + 108 + 4 * k, 1, 1, 0, 1, 7 - k, 7 - k, 7 - k);
    ex(s + 122, 0, 0, 0, 1, 4, 4, 4);
    go(0);
    repeat (121) @(negedge clk);
    stop_a = 1;
    @(negedge clk);
    stop_a = 0;
    repeat (5) @(negedge clk);
    chk("loop_q", 64'(q.size()), 64'(0));
    // asynchronous reset in the middle of a fade
    s = cyc + 1;
    ex(s, 1, 1, 0, 0, 4, 4, 4);
    ex(s + 4, 1, 1, 0, 0, 5, 5, 5);
    go(0);
    repeat (6) @(negedge clk);
    #1 reset_n = 0;
    #1 chk("async_reset", 64'(obs_a), 64'(0));
    chk("async_q", 64'(q.size()), 64'(0));
    repeat (3) @(negedge clk);
    #2 reset_n = 1;
    repeat (10) @(negedge clk);
    chk("post_reset_idle", 64'(obs_a), 64'(0));
    // live rewrite of the active step's target
    wr(0, 7, 0, 0, 0);
    cfg_last = 0; cfg_loop = 0;
    s = cyc + 1;
    ex(s, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) ex(s + 4 * k, 1, 1, 0, 0, k, 0, 0);
    ex(s + 20, 1, 1, 0, 0, 3, 0, 0);
    ex(s + 24, 1, 1, 0, 0, 2, 0, 0);
    ex(s + 32, 1, 0, 1, 0, 2, 0, 0);
    ex(s + 33, 1, 0, 0, 0, 2, 0, 0);
    go(0);
    repeat (16) @(negedge clk);
    wr(0, 2, 0, 0, 0);
    repeat (25) @(negedge clk);
    chk("rewrite_q", 64'(q.size()), 64'(0));
    // COUNT=5 saturation, ignored write to index 3, cfg_last clamped to 2, TICK_DIV=1
    sel = 1;
    @(negedge clk);
    wr(0, 7, 0, 0, 0);
    wr(1, 0, 2, 0, 0);
    wr(2, 0, 0, 5, 0);
    wr(3, 1, 1, 1, 0);
    cfg_last = 3; cfg_loop = 0;
    s = cyc + 1;
    ex(s, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) ex(s + k, 1, 1, 0, 0, k, 0, 0);
    ex(s + 7, 1, 1, 0, 1, 5, 0, 0);
    for (int k = 1; k <= 5; k++) ex(s + 7 + k, 1, 1, 0, 1, 5 - k, k < 2 ? k : 2, 0);
    ex(s + 14, 1, 1, 0, 2, 0, 2, 0);
    for (int k = 1; k <= 5; k++) ex(s + 14 + k, 1, 1, 0, 2, 0, k < 2 ? 2 - k : 0, k);
    ex(s + 21, 1, 0, 1, 2, 0, 0, 5);
    ex(s + 22, 1, 0, 0, 2, 0, 0, 5);
    go(1);
    repeat (30) @(negedge clk);
    chk("sat_q", 64'(q.size()), 64'(0));
    chk("sat_end", 64'(obs_b), 64'(pk(1, 0, 0, 2, 0, 0, 5)));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
